// File: rtl/sddt_sweep_master.sv
// Row-sweep command master (ACT, N x RD, PRE per row) with C2H read-beat accounting.
// Optional read-data signature and tlast consistency check: define SDDT_SWEEP_SIGNATURE_EN.
module sddt_sweep_master #(
    parameter int BG_WIDTH    = 2,
    parameter int BANK_WIDTH  = 2,
    parameter int COL_WIDTH   = 10,
    parameter int ROW_WIDTH   = 17,
    parameter int COL_STEP    = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BG_WIDTH-1:0]   cfg_bg,
    input  logic [BANK_WIDTH-1:0] cfg_bank,
    input  logic [ROW_WIDTH-1:0]  cfg_row_start,
    input  logic [15:0]           cfg_row_count,
    input  logic [15:0]           cfg_col_count,
    output logic [127:0]          M_AXIS_CMD_tdata,
    output logic                  M_AXIS_CMD_tvalid,
    input  logic                  M_AXIS_CMD_tready,
    input  logic [511:0]          S_AXIS_C2H_tdata,
    input  logic                  S_AXIS_C2H_tvalid,
    input  logic                  S_AXIS_C2H_tlast,
    output logic                  S_AXIS_C2H_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           beat_count
`ifdef SDDT_SWEEP_SIGNATURE_EN
    ,
    output logic [31:0]           sig
`endif
);

    localparam logic [3:0] OP_ACT = 4'd1;
    localparam logic [3:0] OP_RD  = 4'd2;
    localparam logic [3:0] OP_PRE = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACT,
        S_RD,
        S_PRE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state;
    logic [BG_WIDTH-1:0]   bg_q;
    logic [BANK_WIDTH-1:0] bank_q;
    logic [ROW_WIDTH-1:0]  row;
    logic [COL_WIDTH-1:0]  col;
    logic [15:0]           rows_left;
    logic [15:0]           col_count_q;
    logic [15:0]           cols_left;
    logic [31:0]           expected;
    logic [31:0]           idle_cnt;
    logic                  cmd_hs;
    logic                  beat;

    assign cmd_hs = M_AXIS_CMD_tvalid && M_AXIS_CMD_tready;
    assign beat   = S_AXIS_C2H_tvalid && S_AXIS_C2H_tready;

    function automatic logic [127:0] cmd_word(
        input logic [3:0]            op,
        input logic [BG_WIDTH-1:0]   bg,
        input logic [BANK_WIDTH-1:0] bank,
        input logic [COL_WIDTH-1:0]  c,
        input logic [ROW_WIDTH-1:0]  r
    );
        logic [127:0] w;
        w = '0;
        w[3:0]              = op;
        w[4 +: BG_WIDTH]    = bg;
        w[8 +: BANK_WIDTH]  = bank;
        w[12 +: COL_WIDTH]  = c;
        w[28 +: ROW_WIDTH]  = r;
        return w;
    endfunction

`ifdef SDDT_SWEEP_SIGNATURE_EN
    function automatic logic [31:0] fold512(input logic [511:0] d);
        logic [31:0] f;
        f = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            f = f ^ d[i*32 +: 32];
        end
        return f;
    endfunction
`else
    logic unused_c2h;
    assign unused_c2h = ^{S_AXIS_C2H_tdata, S_AXIS_C2H_tlast};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            bg_q              <= '0;
            bank_q            <= '0;
            row               <= '0;
            col               <= '0;
            rows_left         <= '0;
            col_count_q       <= '0;
            cols_left         <= '0;
            expected          <= '0;
            idle_cnt          <= '0;
            M_AXIS_CMD_tdata  <= '0;
            M_AXIS_CMD_tvalid <= 1'b0;
            S_AXIS_C2H_tready <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
            beat_count        <= '0;
`ifdef SDDT_SWEEP_SIGNATURE_EN
            sig               <= '0;
`endif
        end else begin
            // Beat accounting runs in every busy state; the FSM only ever sets err, never clears it mid-sweep.
            if (beat) begin
                if (beat_count != '1) beat_count <= beat_count + 32'd1;
                if (beat_count == expected) err <= 1'b1;
`ifdef SDDT_SWEEP_SIGNATURE_EN
                sig <= {sig[30:0], sig[31]} ^ fold512(S_AXIS_C2H_tdata);
                if (S_AXIS_C2H_tlast && ({1'b0, beat_count} + 33'd1 != {1'b0, expected}))
                    err <= 1'b1;
`endif
            end

            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bg_q        <= cfg_bg;
                        bank_q      <= cfg_bank;
                        row         <= cfg_row_start;
                        col         <= '0;
                        rows_left   <= cfg_row_count;
                        col_count_q <= cfg_col_count;
                        expected    <= 32'(cfg_row_count) * 32'(cfg_col_count);
                        idle_cnt    <= '0;
                        beat_count  <= '0;
                        err         <= 1'b0;
`ifdef SDDT_SWEEP_SIGNATURE_EN
                        sig         <= '0;
`endif
                        if (cfg_row_count == 16'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state             <= S_ACT;
                            busy              <= 1'b1;
                            S_AXIS_C2H_tready <= 1'b1;
                            M_AXIS_CMD_tvalid <= 1'b1;
                            M_AXIS_CMD_tdata  <= cmd_word(OP_ACT, cfg_bg, cfg_bank, '0, cfg_row_start);
                        end
                    end
                end

                S_ACT: begin
                    if (cmd_hs) begin
                        col       <= '0;
                        cols_left <= col_count_q;
                        if (col_count_q != 16'd0) begin
                            state            <= S_RD;
                            M_AXIS_CMD_tdata <= cmd_word(OP_RD, bg_q, bank_q, '0, row);
                        end else begin
                            state            <= S_PRE;
                            M_AXIS_CMD_tdata <= cmd_word(OP_PRE, bg_q, bank_q, '0, row);
                        end
                    end
                end

                S_RD: begin
                    if (cmd_hs) begin
                        col       <= col + COL_WIDTH'(COL_STEP);
                        cols_left <= cols_left - 16'd1;
                        if (cols_left == 16'd1) begin
                            state            <= S_PRE;
                            M_AXIS_CMD_tdata <= cmd_word(OP_PRE, bg_q, bank_q, '0, row);
                        end else begin
                            M_AXIS_CMD_tdata <= cmd_word(OP_RD, bg_q, bank_q,
                                                         col + COL_WIDTH'(COL_STEP), row);
                        end
                    end
                end

                S_PRE: begin
                    if (cmd_hs) begin
                        rows_left <= rows_left - 16'd1;
                        row       <= row + ROW_WIDTH'(1);
                        if (rows_left == 16'd1) begin
                            state             <= S_WAIT;
                            M_AXIS_CMD_tvalid <= 1'b0;
                            M_AXIS_CMD_tdata  <= '0;
                            idle_cnt          <= '0;
                        end else begin
                            state            <= S_ACT;
                            M_AXIS_CMD_tdata <= cmd_word(OP_ACT, bg_q, bank_q, '0,
                                                         row + ROW_WIDTH'(1));
                        end
                    end
                end

                S_WAIT: begin
                    if (beat_count == expected) begin
                        state             <= S_DONE;
                        done              <= 1'b1;
                        busy              <= 1'b0;
                        S_AXIS_C2H_tready <= 1'b0;
                    end else if (idle_cnt == 32'(TIMEOUT_CYC)) begin
                        state             <= S_DONE;
                        done              <= 1'b1;
                        busy              <= 1'b0;
                        S_AXIS_C2H_tready <= 1'b0;
                        err               <= 1'b1;
                    end else begin
                        idle_cnt <= beat ? '0 : idle_cnt + 32'd1;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state             <= S_IDLE;
                    busy              <= 1'b0;
                    done              <= 1'b0;
                    S_AXIS_C2H_tready <= 1'b0;
                    M_AXIS_CMD_tvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sddt_sweep_master.sv
// Randomized bench for sddt_sweep_master: command words and beat accounting checked against a sweep model.
module tb_sddt_sweep_master;

    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   cfg_bg = '0;
    logic [1:0]   cfg_bank = '0;
    logic [16:0]  cfg_row_start = '0;
    logic [15:0]  cfg_row_count = '0;
    logic [15:0]  cfg_col_count = '0;
    logic [127:0] cmd_tdata;
    logic         cmd_tvalid;
    logic         cmd_tready = 1'b0;
    logic [511:0] c2h_tdata = '0;
    logic         c2h_tvalid = 1'b0;
    logic         c2h_tlast = 1'b0;
    logic         c2h_tready;
    logic         busy, done, err;
    logic [31:0]  beat_count;
`ifdef SDDT_SWEEP_SIGNATURE_EN
    logic [31:0]  sig;
`endif

    int n_checks = 0;
    int n_bad = 0;
    bit over;

    always #5 clk = ~clk;

    sddt_sweep_master #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_bg(cfg_bg), .cfg_bank(cfg_bank), .cfg_row_start(cfg_row_start),
        .cfg_row_count(cfg_row_count), .cfg_col_count(cfg_col_count),
        .M_AXIS_CMD_tdata(cmd_tdata), .M_AXIS_CMD_tvalid(cmd_tvalid), .M_AXIS_CMD_tready(cmd_tready),
        .S_AXIS_C2H_tdata(c2h_tdata), .S_AXIS_C2H_tvalid(c2h_tvalid), .S_AXIS_C2H_tlast(c2h_tlast),
        .S_AXIS_C2H_tready(c2h_tready),
        .busy(busy), .done(done), .err(err), .beat_count(beat_count)
`ifdef SDDT_SWEEP_SIGNATURE_EN
        , .sig(sig)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [127:0] word(input int op, input logic [1:0] bg, input logic [1:0] bank,
                                          input logic [9:0] c, input logic [16:0] r);
        return {68'd0, 32'(r), 16'(c), 4'(bank), 4'(bg), 4'(op)};
    endfunction

    function automatic logic [31:0] fold(input logic [511:0] d);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) f ^= d[i*32 +: 32];
        return f;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tvalid"}, cmd_tvalid, 0);
        check({tag, "_tdata"}, cmd_tdata, 0);
        check({tag, "_c2h_tready"}, c2h_tready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_beats"}, beat_count, 0);
    endtask

    // mode: 0 tready held high, 1 toggling, 2 random.  exp_done_cyc < 0 skips the latency check.
    task automatic run_sweep(input int rows, input int cols, input logic [16:0] rs,
                             input logic [1:0] bg, input logic [1:0] bank,
                             input int nbeats, input int mode, input bit gaps,
                             input int exp_done_cyc);
        logic [127:0] q[$];
        int exp_tot, n_words, acc, budget, done_cyc;
        logic [31:0] m_sig;
        exp_tot = rows * cols;
        q = {};
        for (int r = 0; r < rows; r++) begin
            q.push_back(word(1, bg, bank, 10'd0, 17'(int'(rs) + r)));
            for (int c = 0; c < cols; c++) q.push_back(word(2, bg, bank, 10'(c * 8), 17'(int'(rs) + r)));
            q.push_back(word(4, bg, bank, 10'd0, 17'(int'(rs) + r)));
        end
        n_words = q.size();
        budget = n_words * 4 + nbeats * 8 + TMO + 60;
        acc = 0;
        m_sig = '0;
        done_cyc = 0;
        over = 0;

        @(posedge clk); #1;
        cfg_bg = bg; cfg_bank = bank; cfg_row_start = rs;
        cfg_row_count = 16'(rows); cfg_col_count = 16'(cols);
        cmd_tready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_bg = 2'($urandom); cfg_bank = 2'($urandom); cfg_row_start = 17'($urandom);
        cfg_row_count = 16'($urandom); cfg_col_count = 16'($urandom);

        fork
            begin : cmd_mon
                bit stalled;
                logic [127:0] held;
                int vcyc;
                stalled = 0; vcyc = 0; held = '0;
                while (!over) begin
                    @(negedge clk);
                    if (cmd_tvalid) begin
                        vcyc++;
                        if (stalled) check("cmd_stable", cmd_tdata, held);
                        if (cmd_tready) begin
                            if (q.size() == 0) check("cmd_extra", cmd_tvalid, 0);
                            else check("cmd_word", cmd_tdata, q.pop_front());
                            stalled = 0;
                        end else begin
                            stalled = 1;
                            held = cmd_tdata;
                        end
                    end else if (stalled) begin
                        check("cmd_dropped", cmd_tvalid, 1);
                        stalled = 0;
                    end
                    @(posedge clk); #1;
                    case (mode)
                        0: cmd_tready = 1'b1;
                        1: cmd_tready = ~cmd_tready;
                        default: cmd_tready = 1'($urandom_range(0, 1));
                    endcase
                end
                check("cmd_left", q.size(), 0);
                if (mode == 0) check("cmd_b2b", vcyc, n_words);
            end
            begin : beat_drv
                int sent;
                bit took, chk_ovr;
                sent = 0; took = 0; chk_ovr = 0;
                while (!over) begin
                    @(posedge clk); #1;
                    if (took) begin
                        c2h_tvalid = 1'b0;
                        c2h_tlast = 1'b0;
                        took = 0;
                    end
                    if (!c2h_tvalid && sent < nbeats && (!gaps || $urandom_range(0, 3) != 0)) begin
                        for (int i = 0; i < 16; i++) c2h_tdata[i*32 +: 32] = $urandom;
                        c2h_tlast = (sent == exp_tot - 1);
                        c2h_tvalid = 1'b1;
                        sent++;
                    end
                    @(negedge clk);
                    if (chk_ovr) begin
                        check("err_overrun", err, 1);
                        chk_ovr = 0;
                    end
                    if (c2h_tvalid && c2h_tready) begin
                        took = 1;
                        acc++;
                        m_sig = {m_sig[30:0], m_sig[31]} ^ fold(c2h_tdata);
                        if (acc > exp_tot) chk_ovr = 1;
                    end
                end
                c2h_tvalid = 1'b0;
                c2h_tlast = 1'b0;
            end
            begin : done_mon
                int cyc;
                cyc = 0;
                while (!over) begin
                    @(negedge clk);
                    cyc++;
                    if (done) begin
                        over = 1;
                        done_cyc = cyc;
                        check("busy_at_done", busy, 0);
                        check("tready_at_done", c2h_tready, 0);
                    end else if (cyc > budget) begin
                        check("done_timeout", done, 1);
                        over = 1;
                    end else if (rows > 0) begin
                        check("busy", busy, 1);
                        check("c2h_tready", c2h_tready, 1);
                    end
                end
            end
        join

        @(negedge clk);
        check("done_pulse", done, 0);
        check("beats_taken", acc, nbeats);
        check("beat_count", beat_count, acc);
        check("err", err, (acc != exp_tot) ? 1 : 0);
        if (exp_done_cyc >= 0) check("done_latency", done_cyc, exp_done_cyc);
`ifdef SDDT_SWEEP_SIGNATURE_EN
        check("sig", sig, m_sig);
`endif
    endtask

    initial begin
        #12;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle");

        // directed cases
        run_sweep(2, 3, 17'h10, 2'd1, 2'd2, 6, 0, 0, -1);
        run_sweep(2, 3, 17'h10, 2'd1, 2'd2, 6, 1, 0, -1);
        run_sweep(1, 0, 17'h55, 2'd3, 2'd0, 0, 0, 0, 4);
        run_sweep(0, 4, 17'h20, 2'd0, 2'd1, 0, 0, 0, 1);
        run_sweep(1, 2, 17'h33, 2'd2, 2'd3, 1, 0, 0, -1);
        run_sweep(1, 1, 17'h44, 2'd1, 2'd1, 2, 0, 0, -1);
        // column and row wrap
        run_sweep(2, 130, 17'h1FFFF, 2'd2, 2'd1, 260, 0, 1, -1);

        // randomized sweeps
        for (int k = 0; k < 8; k++) begin
            int r, c;
            r = $urandom_range(1, 3);
            c = $urandom_range(0, 6);
            run_sweep(r, c, 17'($urandom), 2'($urandom), 2'($urandom), r * c,
                      $urandom_range(0, 2), 1, -1);
        end

        // asynchronous reset in the middle of the RD phase
        @(posedge clk); #1;
        cfg_bg = 2'd1; cfg_bank = 2'd2; cfg_row_start = 17'h100;
        cfg_row_count = 16'd3; cfg_col_count = 16'd8;
        cmd_tready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c2h_tdata = '1;
        c2h_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("mid_rd_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        c2h_tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_rst");
        run_sweep(2, 3, 17'h10, 2'd1, 2'd2, 6, 2, 1, -1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/sddt_sweep_master.md
Name: sddt_sweep_master

Overview:
- Fabric-side counterpart to the core's command and C2H streams.
- Issues a row-sweep command sequence as an AXI-Stream master toward the 128-bit command slave: per row, ACT, then N column reads, then PRE.
- Acts as AXI-Stream slave for the 512-bit C2H read-data stream and counts the returned beats against the expected total.
- Reports done, error and beat count. Used for bring-up and retention sweeps without host DMA.

Parameters:
- BG_WIDTH, 2, bank-group field width
- BANK_WIDTH, 2, bank field width
- COL_WIDTH, 10, column field width
- ROW_WIDTH, 17, row field width
- COL_STEP, 8, column increment between reads (one BL8 burst)
- TIMEOUT_CYC, 65535, max idle cycles waiting for read data

Ports:
- clk  in  1  DDR user clock; all logic single-clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches configuration
- cfg_bg  in  BG_WIDTH  target bank group
- cfg_bank  in  BANK_WIDTH  target bank
- cfg_row_start  in  ROW_WIDTH  first row
- cfg_row_count  in  16  rows to sweep
- cfg_col_count  in  16  reads per row
- M_AXIS_CMD_tdata  out  128  command word
- M_AXIS_CMD_tvalid  out  1  command valid
- M_AXIS_CMD_tready  in  1  command accept
- S_AXIS_C2H_tdata  in  512  read data beat
- S_AXIS_C2H_tvalid  in  1  read data valid
- S_AXIS_C2H_tlast  in  1  ignored for counting; sampled for the signature only
- S_AXIS_C2H_tready  out  1  read data accept
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at completion
- err  out  1  sticky error flag
- beat_count  out  32  C2H beats received in the current sweep

Behaviour:
- Command word layout:
  - [3:0] opcode: 0 NOP, 1 ACT, 2 RD, 4 PRE.
  - [7:4] bg, zero-extended.
  - [11:8] bank, zero-extended.
  - [27:12] col, zero-extended.
  - [59:28] row, zero-extended.
  - [127:60] zero.
- Reset values:
  - M_AXIS_CMD_tvalid=0, M_AXIS_CMD_tdata=0.
  - S_AXIS_C2H_tready=0, busy=0, done=0, err=0, beat_count=0.
  - FSM in IDLE.
- FSM states: IDLE, ACT, RD, PRE, WAIT, DONE.
- IDLE:
  - start latches all cfg_* inputs; beat_count and err clear; expected = row_count*col_count (32-bit unsigned).
  - row_count=0: go to DONE directly, no commands issued.
  - Otherwise go to ACT.
- ACT: drives tvalid=1 with the ACT word for the current row; on the tvalid&tready handshake: go to RD if col_count>0, else PRE.
- RD:
  - Issues a RD word per handshake; col starts at 0 and adds COL_STEP after each handshake, truncated to COL_WIDTH (wraps silently).
  - After col_count handshakes, go to PRE.
- PRE: one PRE word. On handshake: decrement rows remaining; row = row+1 mod 2^ROW_WIDTH; go to ACT if rows remain, else WAIT.
- AXIS master rules:
  - tvalid, once asserted, stays high and tdata stays stable until the handshake.
  - At most one word per cycle.
  - After a handshake the next word may be presented the next cycle, so back-to-back throughput is 1 word/cycle with tready held high.
- WAIT:
  - Exits to DONE when beat_count==expected.
  - An idle counter resets on every accepted beat; if it reaches TIMEOUT_CYC, set err and go to DONE.
- DONE: pulse done for one cycle; busy drops the same cycle; return to IDLE.
- busy=1 in every state except IDLE and DONE.
- S_AXIS_C2H_tready=1 whenever busy=1 (reads may return while commands are still being issued).
- Each tvalid&tready beat increments beat_count, saturating at 2^32-1.
- A beat arriving when beat_count is already equal to expected sets err (overrun); the beat is still accepted.
- start while busy is ignored.
- In IDLE, tready=0.
- Reset mid-sweep: everything returns to reset values immediately; a partially presented command is dropped.

Optional Feature:
- Macro: SDDT_SWEEP_SIGNATURE_EN.
- When defined:
  - Adds output port sig 32 bits: XOR-fold of every accepted 512-bit beat (sixteen 32-bit lanes XORed together), rotated left by 1 before each new beat is XORed in.
  - sig clears on start and holds after DONE.
  - A beat whose tlast=1 while beat_count+1 != expected sets err.
- When not defined: the port and logic are absent; tlast is fully ignored.

Test Plan:
- rows=2, cols=3, row_start=0x10, bg=1, bank=2, tready always 1, return 6 beats:
  - Command sequence: ACT r0x10; RD col 0, 8, 16; PRE; ACT r0x11; RD ×3; PRE. That is 10 words on consecutive cycles.
  - Then done pulse, beat_count=6, err=0.
- Same config with tready toggling 1/0 each cycle: tdata stable while stalled, identical 10-word sequence, no duplicates.
- rows=1, cols=0: ACT, PRE, then immediate done; beat_count=0.
- rows=0: done pulses the cycle after start, no tvalid ever asserted.
- rows=1, cols=2, only 1 beat returned: after TIMEOUT_CYC idle cycles, err=1 and done pulses.
- rows=1, cols=1, 2 beats returned: err=1 on the second beat.
- Additionally: assert rst mid-RD; all outputs return to 0 asynchronously, and a new start then runs a clean sweep.
